i2c_cfg_regbank: RTL and testbench

- Parametrised I2C-slave configuration register bank; next generation of the chip-level system controller that holds PLL, reset, SPI-divider and debug controls.
- Exposes NUM_OUT read/write output registers and NUM_IN read-only input registers behind a 7-bit device address.
- Adds an auto-incrementing register pointer, readback of output registers, NACK on illegal accesses, and per-register write strobes.
- Sits in the always-on 25 MHz reference domain, before the PLLs; consumers in other domains synchronise its outputs externally.

---
 rtl/i2c_cfg_pkg.sv | 30 +++
 rtl/i2c_cfg_line_cond.sv | 68 ++++++
 rtl/i2c_cfg_regbank.sv | 198 +++++++++++++++++++
 tb/tb_i2c_cfg_regbank.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration register bank.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAck,
        StPtr,
        StWdata,
        StRdata,
        StRack,
        StWait
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam int unsigned BYTE_BITS = 8;

    // Register pointer advance with wrap at the end of the combined map.
    function automatic logic [7:0] ptr_inc(input logic [7:0] p, input logic [7:0] total);
        logic [7:0] n;
        n = p + 8'd1;
        return (n == total) ? 8'd0 : n;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_cfg_line_cond.sv
// SCL/SDA conditioning: synchronisers, optional majority filter (I2C_CFG_GLITCH_FILTER_EN),
// SCL edge detection and START/STOP detection.
module i2c_cfg_line_cond
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_c;
    logic                   sda_c;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Idle bus is high, so everything resets to 1 to avoid a false edge at reset release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

`ifdef I2C_CFG_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
        end
    end

    assign scl_c = maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
    assign sda_c = maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
`else
    assign scl_c = scl_sync_q[SYNC_STAGES-1];
    assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

    assign sda_lvl_o  = sda_c;
    assign scl_rise_o = scl_c & ~scl_prev_q;
    assign scl_fall_o = ~scl_c & scl_prev_q;
    assign start_o    = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_o     = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

endmodule

// File: rtl/i2c_cfg_regbank.sv
// I2C slave register bank: NUM_OUT read/write registers followed by NUM_IN read-only
// registers behind an auto-incrementing pointer. Optional filter: I2C_CFG_GLITCH_FILTER_EN.
module i2c_cfg_regbank
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 12,
    parameter int unsigned NUM_IN      = 4,
    parameter logic [6:0]  DEV_ADDR    = 7'h3C,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                     clk,
    input  logic                                     aresetn,
    input  logic                                     scl_i,
    input  logic                                     sda_i,
    output logic                                     sda_o,
    output logic [8*NUM_OUT-1:0]                     reg_out,
    input  logic [8*NUM_OUT-1:0]                     reg_default,
    input  logic [(NUM_IN > 0 ? 8*NUM_IN : 8)-1:0]   reg_in,
    output logic [NUM_OUT-1:0]                       wr_strobe,
    output logic                                     busy
);

    localparam logic [7:0] TOTAL    = 8'(NUM_OUT + NUM_IN);
    localparam logic [7:0] NUM_OUT8 = 8'(NUM_OUT);

    logic sda_lvl, scl_rise, scl_fall, start, stop;

    i2c_cfg_line_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_cond (
        .clk       (clk),
        .aresetn   (aresetn),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_lvl_o (sda_lvl),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    i2c_state_e           state_q, state_d;
    i2c_state_e           ack_nxt_q, ack_nxt_d;
    logic                 ack_ph_q, ack_ph_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [6:0]           sr_q, sr_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           ptr_q, ptr_d;
    logic                 sda_q, sda_d;
    logic [8*NUM_OUT-1:0] reg_q, reg_d;
    logic [NUM_OUT-1:0]   strobe_q, strobe_d;
    logic [7:0]           rx_byte;
    logic [7:0]           rd_byte;
    logic                 load;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            ack_nxt_q <= StIdle;
            ack_ph_q  <= 1'b0;
            cnt_q     <= '0;
            sr_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            sda_q     <= I2C_NACK;
            reg_q     <= reg_default;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            ack_ph_q  <= ack_ph_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_q     <= sda_d;
            reg_q     <= reg_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        ack_ph_d  = ack_ph_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_d     = sda_q;
        reg_d     = reg_q;
        strobe_d  = '0;
        load      = 1'b0;
        rx_byte   = {sr_q, sda_lvl};

        rd_byte = 8'h00;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (ptr_q == 8'(k)) rd_byte = reg_q[8*k +: 8];
        end
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (ptr_q == 8'(NUM_OUT + k)) rd_byte = reg_in[8*k +: 8];
        end

        if (stop) begin
            state_d = StIdle;
            sda_d   = I2C_NACK;
        end else if (start) begin
            state_d  = StAddr;
            cnt_d    = '0;
            ack_ph_d = 1'b0;
            sda_d    = I2C_NACK;
        end else begin
            unique case (state_q)
                StIdle, StWait: ;
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte[6:0];
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'(BYTE_BITS - 1)) begin
                            state_d  = StAck;
                            ack_ph_d = 1'b0;
                            if (state_q == StAddr) begin
                                ack_nxt_d = rx_byte[0] ? StRdata : StPtr;
                                if (rx_byte[7:1] != DEV_ADDR) state_d = StIdle;
                            end else if (state_q == StPtr) begin
                                ack_nxt_d = StWdata;
                                if (rx_byte < TOTAL) ptr_d = rx_byte;
                                else state_d = StWait;
                            end else if (ptr_q < NUM_OUT8) begin
                                for (int unsigned k = 0; k < NUM_OUT; k++) begin
                                    if (ptr_q == 8'(k)) begin
                                        reg_d[8*k +: 8] = rx_byte;
                                        strobe_d[k]     = 1'b1;
                                    end
                                end
                                ptr_d     = ptr_inc(ptr_q, TOTAL);
                                ack_nxt_d = StWdata;
                            end else begin
                                state_d = StWait;
                            end
                        end
                    end
                end
                StAck: begin
                    // First falling edge opens the ACK slot, the second closes it.
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            sda_d    = I2C_ACK;
                            ack_ph_d = 1'b1;
                        end else begin
                            ack_ph_d = 1'b0;
                            cnt_d    = '0;
                            sda_d    = I2C_NACK;
                            state_d  = ack_nxt_q;
                            load     = (ack_nxt_q == StRdata);
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'(BYTE_BITS)) begin
                            sda_d   = I2C_NACK;
                            state_d = StRack;
                        end else begin
                            sda_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                StRack: begin
                    // A falling edge here implies the master ACKed on the preceding rise.
                    if (scl_rise) begin
                        if (sda_lvl != I2C_ACK) state_d = StWait;
                    end else if (scl_fall) begin
                        load = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (load) begin
            tx_d    = {rd_byte[6:0], 1'b0};
            sda_d   = rd_byte[7];
            ptr_d   = ptr_inc(ptr_q, TOTAL);
            cnt_d   = '0;
            state_d = StRdata;
        end
    end

    assign sda_o     = sda_q;
    assign reg_out   = reg_q;
    assign wr_strobe = strobe_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_cfg_regbank.sv
// Directed bench for i2c_cfg_regbank: bit-banged I2C master with a wired-AND SDA line.
module tb_i2c_cfg_regbank;

    localparam int NUM_OUT = 12;
    localparam int NUM_IN  = 4;
    localparam int Q       = 8;

    logic                 clk = 1'b0;
    logic                 aresetn = 1'b0;
    logic                 scl_m = 1'b1;
    logic                 sda_m = 1'b1;
    logic                 sda_o;
    logic                 sda_line;
    logic [8*NUM_OUT-1:0] reg_out;
    logic [8*NUM_OUT-1:0] reg_default;
    logic [8*NUM_IN-1:0]  reg_in;
    logic [NUM_OUT-1:0]   wr_strobe;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_regs [NUM_OUT];
    int strobe_n = 0;
    int strobe_hist [64];
    int busy_cycles = 0;

    assign sda_line = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_cfg_regbank #(
        .NUM_OUT    (NUM_OUT),
        .NUM_IN     (NUM_IN),
        .DEV_ADDR   (7'h3C),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_o      (sda_o),
        .reg_out    (reg_out),
        .reg_default(reg_default),
        .reg_in     (reg_in),
        .wr_strobe  (wr_strobe),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (wr_strobe != '0) begin
            strobe_n <= strobe_n + $countones(wr_strobe);
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_strobe[k] === 1'b1) strobe_hist[strobe_n % 64] <= k;
            end
        end
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    end

    function automatic logic [8*NUM_OUT-1:0] pack_exp();
        logic [8*NUM_OUT-1:0] v;
        for (int k = 0; k < NUM_OUT; k++) v[8*k +: 8] = exp_regs[k];
        return v;
    endfunction

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        sda_m = 1'b1; wait_q(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; wait_q(Q);
        scl_m = 1'b1; wait_q(Q);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_q(Q);
        scl_m = 1'b1; wait_q(Q / 2);
        b = sda_line; wait_q(Q / 2);
        scl_m = 1'b0; wait_q(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) get_bit(d[i]);
        put_bit(ack);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NUM_OUT; k++) exp_regs[k] = 8'h10 + 8'(k);
        exp_regs[0] = 8'd46;
        exp_regs[2] = 8'h21;
        reg_default = pack_exp();
        reg_in = {8'h7E, 8'h72, 8'h71, 8'h70};
        aresetn = 1'b0;
        wait_q(4);
        checks++;
        if (reg_out !== pack_exp()) begin
            errors++; $display("FAIL reset_in_reset reg_out: got %h expected %h", reg_out, pack_exp());
        end
        aresetn = 1'b1;
        wait_q(4);
        checks++;
        if (reg_out !== pack_exp()) begin
            errors++; $display("FAIL reset_reg_out: got %h expected %h", reg_out, pack_exp());
        end
        checks++;
        if (sda_o !== 1'b1) begin errors++; $display("FAIL reset_sda_o: got %b expected 1", sda_o); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (wr_strobe !== '0) begin
            errors++; $display("FAIL reset_strobe: got %h expected 0", wr_strobe);
        end
    endtask

    task automatic test_write();
        logic a;
        logic [7:0] bytes [4];
        int s0;
        bytes[0] = 8'h78; bytes[1] = 8'h02; bytes[2] = 8'h55; bytes[3] = 8'hAA;
        s0 = strobe_n;
        bus_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], a);
            checks++;
            if (a !== 1'b0) begin
                errors++; $display("FAIL write_ack byte %0d: got %b expected 0", i, a);
            end
        end
        bus_stop();
        wait_q(4);
        exp_regs[2] = 8'h55;
        exp_regs[3] = 8'hAA;
        checks++;
        if (reg_out !== pack_exp()) begin
            errors++; $display("FAIL write_regs: got %h expected %h", reg_out, pack_exp());
        end
        checks++;
        if (strobe_n - s0 !== 2) begin
            errors++; $display("FAIL write_strobe_count: got %0d expected 2", strobe_n - s0);
        end
        checks++;
        if (strobe_hist[s0 % 64] !== 2 || strobe_hist[(s0 + 1) % 64] !== 3) begin
            errors++; $display("FAIL write_strobe_order: got %0d,%0d expected 2,3",
                               strobe_hist[s0 % 64], strobe_hist[(s0 + 1) % 64]);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_read_seq();
        logic a;
        logic [7:0] d;
        logic [7:0] exp_d [3];
        logic ack_pat [3];
        int s0;
        exp_d[0] = 8'h11; exp_d[1] = 8'h55; exp_d[2] = 8'hAA;
        ack_pat[0] = 1'b0; ack_pat[1] = 1'b0; ack_pat[2] = 1'b1;
        s0 = strobe_n;
        bus_start();
        write_byte(8'h78, a);
        write_byte(8'h01, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL read_ptr_ack: got %b expected 0", a); end
        bus_start();
        write_byte(8'h79, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", a); end
        for (int i = 0; i < 3; i++) begin
            read_byte(d, ack_pat[i]);
            checks++;
            if (d !== exp_d[i]) begin
                errors++; $display("FAIL read_data byte %0d: got %h expected %h", i, d, exp_d[i]);
            end
        end
        bus_stop();
        // Pointer must have been left at 4.
        bus_start();
        write_byte(8'h79, a);
        read_byte(d, 1'b1);
        bus_stop();
        checks++;
        if (d !== exp_regs[4]) begin
            errors++; $display("FAIL read_ptr_end: got %h expected %h", d, exp_regs[4]);
        end
        checks++;
        if (strobe_n !== s0) begin
            errors++; $display("FAIL read_no_strobe: got %0d expected %0d", strobe_n, s0);
        end
    endtask

    task automatic test_wrap();
        logic a;
        logic [7:0] d;
        bus_start();
        write_byte(8'h78, a);
        write_byte(8'h0F, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wrap_ptr_ack: got %b expected 0", a); end
        bus_start();
        write_byte(8'h79, a);
        read_byte(d, 1'b0);
        checks++;
        if (d !== 8'h7E) begin errors++; $display("FAIL wrap_in_reg: got %h expected 7e", d); end
        read_byte(d, 1'b1);
        checks++;
        if (d !== 8'h2E) begin errors++; $display("FAIL wrap_reg0: got %h expected 2e", d); end
        bus_stop();
    endtask

    task automatic test_illegal();
        logic a;
        int s0;
        s0 = strobe_n;
        bus_start();
        write_byte(8'h78, a);
        write_byte(8'h10, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL illegal_ptr_nack: got %b expected 1", a); end
        bus_stop();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy_after_stop: got %b expected 0", busy); end

        bus_start();
        write_byte(8'h78, a);
        write_byte(8'h0C, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL illegal_ptr12_ack: got %b expected 0", a); end
        write_byte(8'h99, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL illegal_data_nack: got %b expected 1", a); end
        bus_stop();
        checks++;
        if (reg_out !== pack_exp()) begin
            errors++; $display("FAIL illegal_regs: got %h expected %h", reg_out, pack_exp());
        end
        checks++;
        if (strobe_n !== s0) begin
            errors++; $display("FAIL illegal_strobe: got %0d expected %0d", strobe_n - s0, 0);
        end

        bus_start();
        write_byte(8'h7A, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL bad_addr_ack: got %b expected 1", a); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_addr_busy: got %b expected 0", busy); end
        bus_stop();
    endtask

    task automatic test_back_to_back();
        logic a;
        int s0;
        s0 = strobe_n;
        bus_start();
        write_byte(8'h78, a);
        write_byte(8'h0B, a);
        write_byte(8'h3C, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL b2b_last_out_ack: got %b expected 0", a); end
        write_byte(8'h5A, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL b2b_overflow_nack: got %b expected 1", a); end
        bus_stop();
        exp_regs[11] = 8'h3C;
        checks++;
        if (reg_out !== pack_exp()) begin
            errors++; $display("FAIL b2b_regs: got %h expected %h", reg_out, pack_exp());
        end
        checks++;
        if (strobe_n - s0 !== 1 || strobe_hist[s0 % 64] !== 11) begin
            errors++; $display("FAIL b2b_strobe: got count %0d idx %0d expected count 1 idx 11",
                               strobe_n - s0, strobe_hist[s0 % 64]);
        end
    endtask

    task automatic test_glitch();
        int b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_q(10);
        b0 = busy_cycles;
        sda_m = 1'b0;
        wait_q(1);
        sda_m = 1'b1;
        wait_q(20);
        checks++;
`ifdef I2C_CFG_GLITCH_FILTER_EN
        if (busy_cycles !== b0) begin
            errors++; $display("FAIL glitch_filtered: got %0d busy cycles expected 0", busy_cycles - b0);
        end
`else
        if (busy_cycles == b0) begin
            errors++; $display("FAIL glitch_unfiltered: got 0 busy cycles expected >0");
        end
`endif
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_final: got %b expected 0", busy); end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_seq();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
